dmem_unit: RTL and testbench
============================

# dmem_unit

Parametrised, word-organised, byte-addressable data memory for the MEM stage of the pipelined core. It adds to the previous data memory:
- a valid/ready request port with a registered one-cycle response;
- per-lane byte-enable writes;
- correct sign/zero extension for every load size;
- an explicit fault flag for misaligned, out-of-range or illegal-size accesses;
- a hardware clear sequencer that zeroes the array after reset, so the array itself is never reset.

## Interface
- DEPTH_BYTES, 4096: memory size in bytes; power of two, at least 8.
- ADDR_W, 32: request address width.
- DBG_ADDR, 16: byte address of the debug word; multiple of 4, less than DEPTH_BYTES.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned  in  1  zero-extend the load (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  the accepted request was rejected.
- init_busy  out  1  clear sequence in progress.
- dbg_word  out  32  little-endian word at DBG_ADDR, read combinationally.

## Operation
- Storage: DEPTH_BYTES/4 words of 32 bits with four byte lanes. Word index = req_addr[log2(DEPTH_BYTES)-1:2]. Little-endian: byte 0 is bits [7:0].
- FSM states: CLEAR and RUN.
  - rst_n low forces CLEAR and resets the clear counter to 0.
  - CLEAR: writes 0 to word[counter], one word per cycle, for DEPTH_BYTES/4 cycles, then moves to RUN.
  - RUN is terminal until the next reset.
- req_ready = 1 only in RUN; init_busy = 1 only in CLEAR.
- Accept = req_valid & req_ready.
- Fault conditions, evaluated on the accepted request:
  - req_size = 11;
  - halfword with addr[0] ≠ 0;
  - word with addr[1:0] ≠ 0;
  - any address bit at or above log2(DEPTH_BYTES) set.
  
  A faulting store writes nothing. A faulting load returns 0.
- Stores with no fault: byte enables are derived from size and addr[1:0]. The byte goes to lane addr[1:0]; a halfword goes to lanes {addr[1]*2+1, addr[1]*2}; a word goes to all four lanes. Data is replicated across lanes before masking.
- Loads with no fault:
  - byte: lane addr[1:0];
  - halfword: lanes per addr[1];
  - extension: if req_unsigned = 1, zero-extend; otherwise sign-extend from bit 7 (byte) or bit 15 (halfword);
  - word: returned unchanged.
- Store-then-load: a load accepted the cycle after a store to the same word returns the updated data. No bypass is needed because the write commits at the accept edge.
- dbg_word reflects the array contents, so it reads 0 once CLEAR completes.

## Timing
- Reset values:
  - req_ready = 0, init_busy = 1 while rst_n is low;
  - resp_valid = 0, resp_rdata = 0, resp_fault = 0.
- Clear latency: first accept is possible DEPTH_BYTES/4 cycles after the first rising edge with rst_n high.
- Store commit: at the accept edge.
- Load latency: 1 cycle. The accept at edge N gives resp_valid/resp_rdata/resp_fault valid after edge N and held until edge N+1.
- Throughput: one request per cycle. The response has no backpressure. When no request is accepted, resp_valid = 0 and resp_rdata/resp_fault return to 0.
- Reset asserted mid-clear or mid-response:
  - outputs go to their reset values immediately (asynchronous);
  - an in-flight response is dropped;
  - the clear restarts from word 0.
- req_valid during CLEAR: ignored; the requester must hold it until ready.

## Test plan
- Reset, release, DEPTH_BYTES = 64 -> init_busy high for exactly 16 cycles, req_ready rises on cycle 16, dbg_word = 0x00000000.
- SW 0x80FF7F01 @0x10, then LB/LBU/LH/LHU/LW @0x10 and @0x13 -> dbg_word = 0x80FF7F01.
  - LB @0x10 = 0x00000001; LBU @0x13 = 0x00000080; LB @0x13 = 0xFFFFFF80;
  - LH @0x10 = 0x00007F01; LHU @0x12 = 0x000080FF; LH @0x12 = 0xFFFF80FF;
  - LW = 0x80FF7F01.
- SB 0xAA @0x11 over the word above -> LW @0x10 = 0x80FFAA01, all other lanes untouched.
- SH @0x11, SW @0x12, req_size = 11, and an access with an address bit at or above log2(DEPTH_BYTES) set -> resp_fault = 1, resp_rdata = 0, memory unchanged.
- Back-to-back SW 0x12345678 @0x20 then LW @0x20 on the next cycle -> returns 0x12345678 one cycle later. resp_valid is high for two consecutive cycles.
- Assert rst_n low while a load is in flight and re-release -> resp_valid = 0 immediately, full clear repeats, previously written words read 0.

Source files
------------

// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressable data memory with valid/ready requests, a registered response and a hardware clear after reset
module dmem_unit #(
    parameter int DEPTH_BYTES = 4096,
    parameter int ADDR_W      = 32,
    parameter int DBG_ADDR    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_fault_o,
    output logic              init_busy_o,
    output logic [31:0]       dbg_word_o
);
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int CW    = AW - 2;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            ready_q, busy_q, resp_valid_q, resp_fault_q;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic [31:0]     mem_q [WORDS];
    logic [CW-1:0]   idx;
    logic            accept, fault, wr_en;
    logic [3:0]      be;
    logic [31:0]     wd, rd_word;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;

    assign idx     = req_addr_i[AW-1:2];
    assign accept  = req_valid_i & ready_q;
    assign rd_word = mem_q[idx];
    assign wr_en   = accept & req_we_i & ~fault;

    // decode fault, lane enables, replicated store data and extended load data
    always_comb begin
        fault  = (req_size_i == 2'b11) | (req_size_i == 2'b01 & req_addr_i[0])
               | (req_size_i == 2'b10 & |req_addr_i[1:0]) | (|(req_addr_i >> AW));
        be     = req_size_i == 2'b00 ? 4'b0001 << req_addr_i[1:0]
               : req_size_i == 2'b01 ? (req_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd     = req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}}
               : req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
        lane_b = 8'(rd_word >> {req_addr_i[1:0], 3'b000});
        lane_h = req_addr_i[1] ? rd_word[31:16] : rd_word[15:0];
        resp_rdata_d = '0;
        if (accept & ~fault & ~req_we_i)
            resp_rdata_d = req_size_i == 2'b00 ? {{24{lane_b[7] & ~req_unsigned_i}}, lane_b}
                         : req_size_i == 2'b01 ? {{16{lane_h[15] & ~req_unsigned_i}}, lane_h}
                         : rd_word;
    end

    // array is never reset: the clear sequence zeroes it, then stores commit at the accept edge
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            mem_q[cnt_q] <= '0;
        else if (wr_en)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
    end

    // clear/run sequencer with registered handshake flags and the one-cycle response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= accept;
            resp_fault_q <= accept & fault;
            resp_rdata_q <= resp_rdata_d;
            if (state_q == CLEAR) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(WORDS - 1)) begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    assign req_ready_o  = ready_q;
    assign init_busy_o  = busy_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_fault_o = resp_fault_q;
    assign resp_rdata_o = resp_rdata_q;
    assign dbg_word_o   = mem_q[CW'(DBG_ADDR / 4)];
endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: randomized and directed checks of dmem_unit against a byte-array reference model
module tb_dmem_unit;
    localparam int DEPTH = 64;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0, req_we = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_fault, init_busy;
    logic [31:0] resp_rdata, dbg_word;

    logic [7:0]  mm [DEPTH];
    int          errors = 0, checks = 0;

    dmem_unit #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .DBG_ADDR(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(resp_valid),
        .resp_rdata_o(resp_rdata), .resp_fault_o(resp_fault), .init_busy_o(init_busy),
        .dbg_word_o(dbg_word)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic logic [31:0] model_dbg();
        return {mm[19], mm[18], mm[17], mm[16]};
    endfunction

    // reference: an access of n = 2^size bytes is legal only if aligned to n and fully inside the memory
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] exp, output logic ef);
        int n;
        n   = 1 << sz;
        ef  = (sz == 2'b11) || (addr % n != 0) || (addr >= DEPTH);
        exp = 0;
        if (!ef) begin
            if (we) begin
                for (int i = 0; i < n; i++) mm[addr + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) exp |= 32'(mm[addr + i]) << (8 * i);
                if (!uns && n < 4 && exp[8*n-1]) exp |= 32'hFFFF_FFFF << (8 * n);
            end
        end
    endtask

    // drive one request at a falling edge, sample its response at the next falling edge
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic v, output logic f, output logic [31:0] rd,
                        output logic [31:0] exp, output logic ef);
        model(we, sz, uns, addr, wd, exp, ef);
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        v = resp_valid; f = resp_fault; rd = resp_rdata;
        req_valid = 0;
    endtask

    task automatic wait_clear(output int cycles);
        cycles = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cycles++;
            if (!init_busy) break;
        end
    endtask

    task automatic test_reset();
        int cyc;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || init_busy !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b busy=%b rv=%b rd=%h rf=%b, required 0 1 0 0 0",
                     req_ready, init_busy, resp_valid, resp_rdata, resp_fault);
        end
        rst_n = 1;
        wait_clear(cyc);
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL clear_len: got %0d cycles, required 16", cyc); end
        checks++;
        if (req_ready !== 1'b1 || dbg_word !== 32'h0) begin
            errors++;
            $display("FAIL after_clear: ready=%b dbg=%h, required 1 00000000", req_ready, dbg_word);
        end
        for (int i = 0; i < DEPTH; i++) mm[i] = 0;
    endtask

    task automatic test_loads();
        logic v, f, ef;
        logic [31:0] rd, exp;
        logic [1:0]  sz  [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        logic        un  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad  [7] = '{32'h10, 32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h10};
        logic [31:0] req [7] = '{32'h1, 32'h80, 32'hFFFFFF80, 32'h7F01, 32'h80FF, 32'hFFFF80FF, 32'h80FF7F01};
        send(1, 2'd2, 0, 32'h10, 32'h80FF7F01, v, f, rd, exp, ef);
        checks++;
        if (v !== 1'b1 || f !== 1'b0 || rd !== 32'h0 || dbg_word !== 32'h80FF7F01) begin
            errors++;
            $display("FAIL sw_store: v=%b f=%b rd=%h dbg=%h, required 1 0 0 80ff7f01", v, f, rd, dbg_word);
        end
        for (int i = 0; i < 7; i++) begin
            send(0, sz[i], un[i], ad[i], 32'h0, v, f, rd, exp, ef);
            checks++;
            if (v !== 1'b1 || f !== 1'b0 || rd !== req[i]) begin
                errors++;
                $display("FAIL load_%0d: v=%b f=%b rd=%h, required 1 0 %h", i, v, f, rd, req[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        logic v, f, ef;
        logic [31:0] rd, exp;
        send(1, 2'd0, 0, 32'h11, 32'hDEADBEAA, v, f, rd, exp, ef);
        send(0, 2'd2, 0, 32'h10, 32'h0, v, f, rd, exp, ef);
        checks++;
        if (rd !== 32'h80FFAA01 || dbg_word !== 32'h80FFAA01) begin
            errors++;
            $display("FAIL sb_lane: rd=%h dbg=%h, required 80ffaa01", rd, dbg_word);
        end
        send(1, 2'd1, 0, 32'h12, 32'h1234C3D4, v, f, rd, exp, ef);
        checks++;
        if (dbg_word !== 32'hC3D4AA01) begin
            errors++;
            $display("FAIL sh_upper: dbg=%h, required c3d4aa01", dbg_word);
        end
    endtask

    task automatic test_faults();
        logic v, f, ef;
        logic [31:0] rd, exp;
        logic        we [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  sz [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
        logic [31:0] ad [6] = '{32'h11, 32'h12, 32'h10, 32'h10, 32'h50, 32'h80000010};
        for (int i = 0; i < 6; i++) begin
            send(we[i], sz[i], 0, ad[i], 32'hFFFFFFFF, v, f, rd, exp, ef);
            checks++;
            if (v !== 1'b1 || f !== 1'b1 || rd !== 32'h0 || dbg_word !== 32'hC3D4AA01) begin
                errors++;
                $display("FAIL fault_%0d: v=%b f=%b rd=%h dbg=%h, required 1 1 0 c3d4aa01", i, v, f, rd, dbg_word);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic v1, v2, f, ef;
        logic [31:0] rd, exp;
        send(1, 2'd2, 0, 32'h20, 32'h12345678, v1, f, rd, exp, ef);
        send(0, 2'd2, 0, 32'h20, 32'h0, v2, f, rd, exp, ef);
        checks++;
        if (v1 !== 1'b1 || v2 !== 1'b1 || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b: v1=%b v2=%b rd=%h, required 1 1 12345678", v1, v2, rd);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_fault !== 1'b0) begin
            errors++;
            $display("FAIL idle_resp: rv=%b rd=%h rf=%b, required 0 0 0", resp_valid, resp_rdata, resp_fault);
        end
    endtask

    task automatic test_random();
        logic v, f, ef, we, uns;
        logic [1:0]  sz;
        logic [31:0] rd, exp, addr;
        for (int i = 0; i < 300; i++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            addr = $urandom_range(0, DEPTH + 7);
            if ($urandom_range(0, 15) == 0) addr |= 32'h1 << $urandom_range(6, 31);
            send(we, sz, uns, addr, $urandom, v, f, rd, exp, ef);
            checks++;
            if (v !== 1'b1 || f !== ef || rd !== exp || dbg_word !== model_dbg()) begin
                errors++;
                $display("FAIL random_%0d: we=%b sz=%0d addr=%h v=%b f=%b rd=%h dbg=%h, required 1 %b %h %h",
                         i, we, sz, addr, v, f, rd, dbg_word, ef, exp, model_dbg());
            end
        end
    endtask

    task automatic test_reset_midflight();
        int cyc;
        logic v, f, ef;
        logic [31:0] rd, exp;
        send(1, 2'd2, 0, 32'h10, 32'hCAFEF00D, v, f, rd, exp, ef);
        req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h10;
        @(posedge clk);
        #2;
        req_valid = 0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL inflight: rv=%b rd=%h, required 1 cafef00d", resp_valid, resp_rdata);
        end
        rst_n = 0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: rv=%b rd=%h ready=%b busy=%b, required 0 0 0 1",
                     resp_valid, resp_rdata, req_ready, init_busy);
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < DEPTH; i++) mm[i] = 0;
        wait_clear(cyc);
        checks++;
        if (cyc !== 16 || dbg_word !== 32'h0) begin
            errors++;
            $display("FAIL reclear: cycles=%0d dbg=%h, required 16 00000000", cyc, dbg_word);
        end
        send(0, 2'd2, 0, 32'h20, 32'h0, v, f, rd, exp, ef);
        checks++;
        if (v !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL cleared_word: v=%b rd=%h, required 1 00000000", v, rd);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_byte_store();
        test_faults();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
